// File: rtl/hex_scroller.sv
// hex_scroller
// Feeds the 4-digit hex display driver (dispHex16) with a 4-nibble window
// that rotates through a latched message of MSG_LEN nibbles. The window moves
// one position every TICK_DIV clocks, left or right, and can be paused,
// restarted or stopped. A one-cycle pulse marks each step that lands on
// position 0.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   msg_in      message, nibble k = msg_in[4k+3:4k], nibble 0 shown first
//   start       pulse: latch msg_in and scroll from position 0
//   stop        pulse: return to idle, freeze the current window
//   pause       level: freeze scrolling while high
//   dir         0 = scroll left (position up), 1 = scroll right (position down)
//   out_hex     window, [15:12] is the leftmost digit
//   busy        high while running or paused
//   wrap_pulse  one cycle, coincident with the window update to position 0

module hex_scroller #(
  parameter int MSG_LEN  = 8,
  parameter int TICK_DIV = 25_000_000,
  parameter int PW       = $clog2(MSG_LEN)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4*MSG_LEN-1:0]   msg_in,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   pause,
  input  logic                   dir,
  output logic [15:0]            out_hex,
  output logic                   busy,
  output logic                   wrap_pulse
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(MSG_LEN - 1);
  localparam logic [PW-1:0] POS_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] POS_ONE   = PW'(1);
  localparam logic [PW:0]   LEN_W     = (PW + 1)'(MSG_LEN);

  typedef logic [MSG_LEN-1:0][3:0] msg_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t          state_r;
  msg_t            msg_r;
  logic [PW-1:0]   pos_r;
  logic [TW-1:0]   tick_cnt_r;
  logic [15:0]     out_hex_r;
  logic            busy_r;
  logic            wrap_r;
  logic [15:0]     window_ref_s;
  logic            state_idle_s;

  // Next position when scrolling left, wrapping MSG_LEN-1 -> 0.
  function automatic logic [PW-1:0] pos_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = (p == POS_LAST) ? POS_ZERO : (p + POS_ONE);
    return r;
  endfunction

  // Next position when scrolling right, wrapping 0 -> MSG_LEN-1.
  function automatic logic [PW-1:0] pos_dec(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    r = (p == POS_ZERO) ? POS_LAST : (p - POS_ONE);
    return r;
  endfunction

  // Nibble at message index (p + off) mod MSG_LEN. p < MSG_LEN and off <= 3
  // with MSG_LEN >= 4, so a single conditional subtract is enough.
  function automatic logic [3:0] nib_at(input msg_t m, input logic [PW-1:0] p,
                                        input logic [1:0] off);
    logic [PW:0] sum;
    logic [PW:0] idx;
    sum = {1'b0, p} + {{(PW - 1){1'b0}}, off};
    idx = (sum >= LEN_W) ? (sum - LEN_W) : sum;
    return m[idx[PW-1:0]];
  endfunction

  // Four-nibble window starting at position p, first nibble leftmost.
  function automatic logic [15:0] window_f(input msg_t m, input logic [PW-1:0] p);
    return {nib_at(m, p, 2'd0), nib_at(m, p, 2'd1),
            nib_at(m, p, 2'd2), nib_at(m, p, 2'd3)};
  endfunction

  // Scroll controller: state, message, position, step counter and outputs.
  // out_hex is registered alongside pos so it always equals window_f(msg, pos)
  // and carries no combinational path from the inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      msg_r      <= '{default: 4'h0};
      pos_r      <= POS_ZERO;
      tick_cnt_r <= {TW{1'b0}};
      out_hex_r  <= 16'h0000;
      busy_r     <= 1'b0;
      wrap_r     <= 1'b0;
    end else begin
      wrap_r <= 1'b0;
      if (stop) begin
        // Window freezes: pos and msg hold.
        state_r    <= ST_IDLE;
        tick_cnt_r <= {TW{1'b0}};
        busy_r     <= 1'b0;
      end else if (start) begin
        // A load to position 0 never pulses wrap.
        state_r    <= ST_RUN;
        msg_r      <= msg_t'(msg_in);
        pos_r      <= POS_ZERO;
        tick_cnt_r <= {TW{1'b0}};
        out_hex_r  <= window_f(msg_t'(msg_in), POS_ZERO);
        busy_r     <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
          ST_RUN, ST_PAUSED: begin
            busy_r <= 1'b1;
            if (pause) begin
              // Entry edge and every paused edge hold the count.
              state_r <= ST_PAUSED;
            end else begin
              // The release edge counts, so pause costs exactly one cycle
              // per paused edge.
              state_r <= ST_RUN;
              if (tick_cnt_r == TICK_LAST) begin
                tick_cnt_r <= {TW{1'b0}};
                if (dir) begin
                  pos_r     <= pos_dec(pos_r);
                  out_hex_r <= window_f(msg_r, pos_dec(pos_r));
                  wrap_r    <= (pos_r == POS_ONE);
                end else begin
                  pos_r     <= pos_inc(pos_r);
                  out_hex_r <= window_f(msg_r, pos_inc(pos_r));
                  wrap_r    <= (pos_r == POS_LAST);
                end
              end else begin
                tick_cnt_r <= tick_cnt_r + TW'(1);
              end
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= {TW{1'b0}};
            busy_r     <= 1'b0;
          end
        endcase
      end
    end
  end

  // Reference window and idle flag for the checker.
  always_comb begin
    window_ref_s = window_f(msg_r, pos_r);
    state_idle_s = (state_r == ST_IDLE);
  end

  assign out_hex    = out_hex_r;
  assign busy       = busy_r;
  assign wrap_pulse = wrap_r;

  hex_scroller_chk #(
    .PW        (PW),
    .TW        (TW),
    .POS_LAST  (POS_LAST),
    .TICK_LAST (TICK_LAST)
  ) u_chk (
    .clk        (clk),
    .rst        (rst),
    .out_hex    (out_hex_r),
    .window_ref (window_ref_s),
    .busy       (busy_r),
    .state_idle (state_idle_s),
    .wrap_pulse (wrap_r),
    .pos        (pos_r),
    .tick_cnt   (tick_cnt_r)
  );

endmodule

// hex_scroller_chk
// Structural invariants of hex_scroller.
//
// Ports
//   clk, rst     clock and asynchronous active-high reset
//   out_hex      registered window
//   window_ref   window recomputed from message and position registers
//   busy         registered busy flag
//   state_idle   state register is IDLE
//   wrap_pulse   registered wrap pulse
//   pos          position register
//   tick_cnt     step counter register
module hex_scroller_chk #(
  parameter int             PW        = 3,
  parameter int             TW        = 2,
  parameter logic [PW-1:0]  POS_LAST  = '1,
  parameter logic [TW-1:0]  TICK_LAST = '1
) (
  input logic          clk,
  input logic          rst,
  input logic [15:0]   out_hex,
  input logic [15:0]   window_ref,
  input logic          busy,
  input logic          state_idle,
  input logic          wrap_pulse,
  input logic [PW-1:0] pos,
  input logic [TW-1:0] tick_cnt
);

  a_window : assert property (@(posedge clk) disable iff (rst) out_hex == window_ref);
  a_busy   : assert property (@(posedge clk) disable iff (rst) busy == !state_idle);
  a_wrap   : assert property (@(posedge clk) disable iff (rst) wrap_pulse |-> (pos == {PW{1'b0}}));
  a_pos    : assert property (@(posedge clk) disable iff (rst) pos <= POS_LAST);
  a_tick   : assert property (@(posedge clk) disable iff (rst) tick_cnt <= TICK_LAST);

endmodule

// File: tb/tb_hex_scroller.sv
// Directed bench for hex_scroller with MSG_LEN=6, TICK_DIV=4.
module tb_hex_scroller;

  localparam int MSG_LEN  = 6;
  localparam int TICK_DIV = 4;

  logic                 clk    = 1'b0;
  logic                 clk_en = 1'b0;
  logic                 rst    = 1'b0;
  logic [4*MSG_LEN-1:0] msg_in = 24'h654321;
  logic                 start  = 1'b0;
  logic                 stop   = 1'b0;
  logic                 pause  = 1'b0;
  logic                 dir    = 1'b0;
  logic [15:0]          out_hex;
  logic                 busy;
  logic                 wrap_pulse;

  int errors = 0;
  int checks = 0;

  logic [15:0] left_exp  [6] = '{16'h2345, 16'h3456, 16'h4561, 16'h5612, 16'h6123, 16'h1234};
  logic        left_wrap [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [15:0] prev_win;

  hex_scroller #(
    .MSG_LEN  (MSG_LEN),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .msg_in     (msg_in),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .dir        (dir),
    .out_hex    (out_hex),
    .busy       (busy),
    .wrap_pulse (wrap_pulse)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with the clock stopped.
    #2 rst = 1'b1;
    #1;
    chk("reset_out_hex", out_hex, 16'h0000);
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk("reset_wrap", {15'd0, wrap_pulse}, 16'd0);
    clk_en = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);

    // Left scroll through a full revolution.
    dir = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("left_load", out_hex, 16'h1234);
    chk("left_busy", {15'd0, busy}, 16'd1);
    chk("left_load_wrap", {15'd0, wrap_pulse}, 16'd0);
    prev_win = 16'h1234;
    for (int i = 0; i < 6; i++) begin
      tick(3);
      chk("left_hold", out_hex, prev_win);
      tick(1);
      chk("left_step", out_hex, left_exp[i]);
      chk("left_wrap", {15'd0, wrap_pulse}, {15'd0, left_wrap[i]});
      prev_win = left_exp[i];
    end
    tick(1);
    chk("left_wrap_one_cycle", {15'd0, wrap_pulse}, 16'd0);

    // Stop freezes the window.
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    chk("stop_busy", {15'd0, busy}, 16'd0);
    chk("stop_window", out_hex, 16'h1234);
    tick(5);
    chk("stop_frozen", out_hex, 16'h1234);

    // Right scroll, then a mid-interval direction change.
    dir = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("right_load", out_hex, 16'h1234);
    tick(4);
    chk("right_step1", out_hex, 16'h6123);
    chk("right_step1_wrap", {15'd0, wrap_pulse}, 16'd0);
    tick(4);
    chk("right_step2", out_hex, 16'h5612);
    tick(2);
    dir = 1'b0;
    tick(1);
    chk("dir_change_hold", out_hex, 16'h5612);
    tick(1);
    chk("dir_change_step", out_hex, 16'h6123);

    // Pause at tick_cnt = 2 for 10 cycles.
    tick(2);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("pause_hold", out_hex, 16'h6123);
    end
    chk("pause_busy", {15'd0, busy}, 16'd1);
    pause = 1'b0;
    tick(1);
    chk("release_edge", out_hex, 16'h6123);
    tick(1);
    chk("release_step", out_hex, 16'h1234);
    chk("release_wrap", {15'd0, wrap_pulse}, 16'd1);

    // stop beats start.
    tick(4);
    chk("pre_prio", out_hex, 16'h2345);
    msg_in = 24'hABCDEF;
    stop = 1'b1; start = 1'b1;
    tick(1);
    stop = 1'b0; start = 1'b0;
    msg_in = 24'h654321;
    chk("prio_busy", {15'd0, busy}, 16'd0);
    chk("prio_window", out_hex, 16'h2345);

    // start with pause high: loads, then stays paused.
    pause = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("start_pause_load", out_hex, 16'h1234);
    chk("start_pause_busy", {15'd0, busy}, 16'd1);
    tick(8);
    chk("start_pause_hold", out_hex, 16'h1234);
    chk("start_pause_busy2", {15'd0, busy}, 16'd1);
    pause = 1'b0;

    // Restart from position 3 with a new message.
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(12);
    chk("restart_pre_pos3", out_hex, 16'h4561);
    tick(1);
    msg_in = 24'hABCDEF; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("restart_window", out_hex, 16'hFEDC);
    chk("restart_tick_cnt", {14'd0, dut.tick_cnt_r}, 16'd0);
    chk("restart_busy", {15'd0, busy}, 16'd1);
    tick(3);
    chk("restart_hold", out_hex, 16'hFEDC);
    tick(1);
    chk("restart_step", out_hex, 16'hEDCB);

    // Asynchronous reset mid-scroll, between clock edges.
    tick(2);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_hex", out_hex, 16'h0000);
    chk("async_rst_busy", {15'd0, busy}, 16'd0);
    chk("async_rst_wrap", {15'd0, wrap_pulse}, 16'd0);
    tick(1);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_scroller.md
# hex_scroller

- Upstream feeder for the 4-digit hex display driver, `dispHex16`; `out_hex` connects directly to its `in_hex`.
- Latches a message of `MSG_LEN` hex nibbles.
- Presents a rotating 4-nibble window of the message, one step every `TICK_DIV` clocks, left or right.
- Supports pause/resume and stop, and reports each wrap of the window back to the message start.

## Interface
- `MSG_LEN`, 8: message length in nibbles; legal range 4..64.
- `TICK_DIV`, 25_000_000: clocks per scroll step; legal minimum 2.
- `PW`, $clog2(MSG_LEN): width of the window position register.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `msg_in`  in  4*MSG_LEN  message; nibble k = `msg_in[4k+3:4k]`, nibble 0 is the first character.
- `start`  in  1  single-cycle pulse: latch `msg_in` and begin scrolling from position 0.
- `stop`  in  1  single-cycle pulse: halt scrolling, return to idle.
- `pause`  in  1  level: freeze scrolling while high.
- `dir`  in  1  0 = scroll left (position increments), 1 = scroll right (position decrements).
- `out_hex`  out  16  window to display; [15:12] is the leftmost digit.
- `busy`  out  1  high in RUN or PAUSED.
- `wrap_pulse`  out  1  one-cycle pulse when a step lands on position 0.

## Operation
- **Registers**
  - `msg_reg`: message latched on `start`.
  - `pos`: window position, 0..MSG_LEN-1.
  - `tick_cnt`: step counter, 0..TICK_DIV-1.
  - `state`: IDLE, RUN or PAUSED.
- **Window function**
  - Nibble index wraps mod MSG_LEN.
  - `out_hex` = {msg[pos], msg[pos+1], msg[pos+2], msg[pos+3]}.
  - `out_hex` is computed only from `msg_reg` and `pos`, so it has no combinational path from inputs.
- **Reset**
  - `state` = IDLE; `msg_reg`, `pos` and `tick_cnt` = 0.
  - `out_hex` = 16'h0000, `busy` = 0, `wrap_pulse` = 0.
- **IDLE**
  - Holds the current window.
  - `start` → load `msg_reg`, `pos` = 0, `tick_cnt` = 0, go to RUN.
- **RUN**
  - `tick_cnt` increments every clock.
  - At TICK_DIV-1: `tick_cnt` → 0 and one step occurs.
    - `dir` = 0: `pos` = (pos+1) mod MSG_LEN.
    - `dir` = 1: `pos` = (pos-1) mod MSG_LEN; from 0 this gives MSG_LEN-1.
  - `dir` is sampled only on the step cycle, so changing direction mid-interval is legal.
  - `pause` high → go to PAUSED; `tick_cnt` holds and no step occurs that cycle.
- **PAUSED**
  - `pos` and `tick_cnt` hold.
  - `pause` low → go to RUN; counting resumes from the held `tick_cnt`.
- **`start` in RUN or PAUSED**: restart. Reload `msg_reg`, `pos` = 0, `tick_cnt` = 0, go to RUN.
- **`stop` in any state**: go to IDLE. `pos` and `msg_reg` hold, so the display freezes on the current window. `tick_cnt` → 0.
- **Priority**: `stop` > `start` > `pause` > tick step.
  - `start` with `pause` high: load, then enter PAUSED on the next cycle.
- **`wrap_pulse`**: high for exactly the one cycle following any step that sets `pos` = 0. A load to position 0 by `start` does not pulse.

## Timing
- `start` sampled at edge E0:
  - After E0: new window on `out_hex`, `busy` = 1.
  - First step at edge E0+TICK_DIV; subsequent steps every TICK_DIV edges.
- **Step latency**: `out_hex` and `pos` change on the same edge where `tick_cnt` wraps.
- **Pause accounting**: each cycle spent paused delays all later steps by one cycle, i.e. the time to the next step = TICK_DIV minus the counts already elapsed.
- **`stop`**: `busy` = 0 the cycle after `stop` is sampled.
- **`wrap_pulse`**: coincident with the `out_hex` update to position 0.
- **Reset asserted mid-scroll**: all outputs go to reset values immediately, without waiting for `clk`.

## Test plan
Common bench setup: MSG_LEN=6, TICK_DIV=4, `msg_in` = 24'h654321.
- **Reset**: assert `rst` with `clk` stopped → `out_hex` = 0000, `busy` = 0 immediately.
- **Left scroll**:
  - Stimulus: `start` pulse, `dir` = 0.
  - `out_hex` = 1234 after E0.
  - Then every 4 clocks: 2345, 3456, 4561, 5612, 6123, 1234.
  - `wrap_pulse` is high for one cycle with the final 1234 only.
- **Right scroll and mid-run direction change**:
  - `start` with `dir` = 1 → 1234, then 6123 (with `wrap_pulse` = 0), then 5612.
  - Set `dir` = 0 two clocks before the next step → next window is 6123.
- **Pause**:
  - Stimulus: in RUN at `tick_cnt` = 2, hold `pause` high for 10 cycles.
  - `out_hex` is constant throughout the pause.
  - After release, the next step occurs exactly 2 clocks later (1 remaining count + the release edge).
- **Priority**:
  - `stop` and `start` in the same cycle → IDLE, `busy` = 0, window unchanged.
  - `start` with `pause` high → window 1234, PAUSED, no steps.
- **Restart**: in RUN at `pos` = 3, pulse `start` with `msg_in` = 24'hABCDEF → `out_hex` = FEDC next cycle, `tick_cnt` = 0.
